branch_predictor: RTL and testbench
===================================

# branch_predictor

Combined branch target buffer (BTB) and pattern history table (BHT) feeding the fetch next-PC logic.
- **IF1:** looks up the IF1 PC and returns the hit, type, 2-bit prediction and target in the same cycle.
- **EX:** accepts resolved branch/jump outcomes, updates the tables and returns `prediction_status` combinationally for the redirect/flush decision.
- Also keeps saturating performance counters for branches and mispredicts.

## Interface
Parameters:
- `BTB_ENTRIES`, default 64: BTB entries, direct-mapped, power of 2.
- `BHT_ENTRIES`, default 256: 2-bit counters, PC-indexed, untagged, power of 2.

Ports:
- `clk`  in  1  clock. One clock; reset is synchronous and active-low.
- `rst_n`  in  1  synchronous active-low reset.
- `IF1_pc`  in  32  fetch PC being looked up.
- `IF1_BTBhit`  out  1  valid entry with matching tag.
- `IF1_Branch`  out  1  hit entry is a conditional branch; 0 on miss.
- `IF1_Jump`  out  1  hit entry is a JAL; 0 on miss.
- `IF1_branch_prediction`  out  2  BHT counter for `IF1_pc`, valid on hit or miss.
- `IF1_pc_imm`  out  32  stored target; 0 on miss.
- `EX_valid`  in  1  EX holds a real, unflushed instruction.
- `EX_Branch`, `EX_Jump`, `EX_ALUSrc`  in  1 each  EX control; JAL = `EX_Jump` with `EX_ALUSrc`=0.
- `EX_pc`, `EX_pc_imm`  in  32  EX instruction PC and PC-relative target.
- `EX_taken`  in  1  resolved branch outcome.
- `EX_branch_prediction`  in  2  counter value carried down the pipe with the instruction.
- `prediction_status`  out  2  0 = predicted not-taken, was taken; 1 = predicted taken, was not; 2 = correct not-taken; 3 = correct taken.
- `branch_count`, `mispredict_count`  out  32 each  performance counters.

## Operation
- **Indexing**
  - BTB index = `pc[log2(BTB_ENTRIES)+1:2]`; tag = `pc[31:log2(BTB_ENTRIES)+2]`.
  - BHT index = `pc[log2(BHT_ENTRIES)+1:2]`.
- **BTB entry fields:** valid, tag, target[31:0], is_branch, is_jump.
- **Lookup:** purely combinational from table registers; no lookup state.
- **Predicted taken:** `EX_branch_prediction[1]`=1, i.e. counter values 2'b10 and 2'b11.
- **`prediction_status`:** combinational from `EX_branch_prediction[1]` and `EX_taken`. Meaningful only when `EX_valid && EX_Branch`; otherwise drives 2.
- **Update:** all writes happen at the clock edge with `EX_valid`=1 and `rst_n`=1.
  - **Branch, counter:** BHT counter at the `EX_pc` index updates from the stored table value, not the carried one. Taken: increment, saturating at 3. Not taken: decrement, saturating at 0.
  - **Branch, taken:** write the BTB entry with valid=1, tag, target=`EX_pc_imm`, is_branch=1, is_jump=0. This allocates or overwrites on a tag mismatch.
  - **Branch, not taken:** BTB unchanged; an existing entry stays.
  - **JAL:** write the BTB entry with target=`EX_pc_imm`, is_jump=1, is_branch=0. The BHT is not touched.
  - **JALR** (`EX_Jump` with `EX_ALUSrc`=1): no BTB or BHT write, because the target is register-dependent.
  - **Anything else**, or `EX_valid`=0: no write.
- **Perf counters:**
  - `branch_count` +1 per valid EX branch.
  - `mispredict_count` +1 when `prediction_status` is 0 or 1.
  - Both saturate at 32'hFFFFFFFF.

## Timing
- **Lookup latency:** 0 cycles, combinational from `IF1_pc`.
- **Update visibility:** an update is visible to lookups from the cycle after the write edge.
- **Same-index read/write:** a read and write to the same index in one cycle returns the old contents.
- **Reset** (`rst_n`=0 sampled at an edge):
  - all BTB valid bits cleared;
  - all BHT counters set to 2'b01, weakly not-taken;
  - perf counters set to 0.
- **Outputs after reset:** `IF1_BTBhit`, `IF1_Branch`, `IF1_Jump` and `IF1_pc_imm` read 0; `IF1_branch_prediction` reads 01.
- **Reset mid-operation:** an EX update presented in the same cycle as reset is dropped; reset wins.
- **Aliasing:** BHT aliasing is tolerated silently. A BTB tag mismatch is a miss, and the entry is replaced only by a taken branch or a JAL.
- **Flushed EX:** the pipeline must deassert `EX_valid` for flushed EX slots; the block does not gate on flush itself.

## Test plan
1. **Post-reset lookup:** reset, then `IF1_pc`=0x100 -> `IF1_BTBhit`=0, `IF1_branch_prediction`=01, `IF1_pc_imm`=0, both perf counters 0.
2. **Training a taken branch:** EX branch at 0x100, target 0x80, `EX_taken`=1, `EX_branch_prediction`=01.
   - Same cycle: `prediction_status`=0.
   - Next cycle, lookup 0x100 -> hit, `IF1_Branch`=1, prediction 10, `IF1_pc_imm`=0x80.
   - Two more taken resolves -> counter 11, then stays 11.
   - `mispredict_count`=1, `branch_count`=3.
3. **Not-taken from 11:** resolve not-taken with carried 11 -> `prediction_status`=1, counter 10. Resolve again -> counter 01. BTB entry is still hit.
4. **BTB aliasing:** JAL at 0x200 (same index as 0x100, different tag) with target 0x400.
   - Lookup 0x200 -> hit, `IF1_Jump`=1, `IF1_pc_imm`=0x400.
   - Lookup 0x100 -> miss.
   - BHT counter at index 0x100/0x200 is unchanged.
5. **JALR and invalid EX:** JALR at 0x300 (`EX_ALUSrc`=1) -> lookup 0x300 misses. A branch with `EX_valid`=0 -> no table or counter change.
6. **Reset beats update:** reset asserted in the same cycle as a taken-branch update at 0x100 -> next cycle the lookup misses, prediction is 01 and the counters are 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Combined direct-mapped BTB and PC-indexed 2-bit BHT for the fetch next-PC path.
// IF1 lookup is purely combinational; EX resolutions update the tables and perf counters.
module branch_predictor #(
    parameter int BTB_ENTRIES = 64,
    parameter int BHT_ENTRIES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IF1_pc,
    output logic        IF1_BTBhit,
    output logic        IF1_Branch,
    output logic        IF1_Jump,
    output logic [1:0]  IF1_branch_prediction,
    output logic [31:0] IF1_pc_imm,
    input  logic        EX_valid,
    input  logic        EX_Branch,
    input  logic        EX_Jump,
    input  logic        EX_ALUSrc,
    input  logic [31:0] EX_pc,
    input  logic [31:0] EX_pc_imm,
    input  logic        EX_taken,
    input  logic [1:0]  EX_branch_prediction,
    output logic [1:0]  prediction_status,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int BTB_IW = $clog2(BTB_ENTRIES);
    localparam int BHT_IW = $clog2(BHT_ENTRIES);
    localparam int TAG_W  = 30 - BTB_IW;

    logic              btb_valid     [BTB_ENTRIES];
    logic [TAG_W-1:0]  btb_tag       [BTB_ENTRIES];
    logic [31:0]       btb_target    [BTB_ENTRIES];
    logic              btb_is_branch [BTB_ENTRIES];
    logic              btb_is_jump   [BTB_ENTRIES];
    logic [1:0]        bht           [BHT_ENTRIES];

    logic [BTB_IW-1:0] if1_btb_idx;
    logic [TAG_W-1:0]  if1_tag;
    logic [BHT_IW-1:0] if1_bht_idx;
    logic              if1_hit;

    logic [BTB_IW-1:0] ex_btb_idx;
    logic [TAG_W-1:0]  ex_tag;
    logic [BHT_IW-1:0] ex_bht_idx;
    logic              ex_branch;
    logic              ex_jal;
    logic [1:0]        ex_bht_old;
    logic [1:0]        ex_bht_new;
    logic              mispredict;
    logic              unused_bits;

    assign if1_btb_idx = IF1_pc[BTB_IW+1:2];
    assign if1_tag     = IF1_pc[31:BTB_IW+2];
    assign if1_bht_idx = IF1_pc[BHT_IW+1:2];
    assign if1_hit     = btb_valid[if1_btb_idx] && (btb_tag[if1_btb_idx] == if1_tag);

    assign IF1_BTBhit            = if1_hit;
    assign IF1_Branch            = if1_hit & btb_is_branch[if1_btb_idx];
    assign IF1_Jump              = if1_hit & btb_is_jump[if1_btb_idx];
    assign IF1_pc_imm            = if1_hit ? btb_target[if1_btb_idx] : 32'd0;
    assign IF1_branch_prediction = bht[if1_bht_idx];

    assign ex_btb_idx = EX_pc[BTB_IW+1:2];
    assign ex_tag     = EX_pc[31:BTB_IW+2];
    assign ex_bht_idx = EX_pc[BHT_IW+1:2];
    assign ex_branch  = EX_valid & EX_Branch;
    // JALR targets depend on a register, so only PC-relative JAL is cached
    assign ex_jal     = EX_valid & EX_Jump & ~EX_ALUSrc & ~EX_Branch;
    assign ex_bht_old = bht[ex_bht_idx];

    assign unused_bits = ^{IF1_pc[1:0], EX_pc[1:0], EX_branch_prediction[0]};

    always_comb begin
        ex_bht_new = ex_bht_old;
        if (EX_taken) begin
            if (ex_bht_old != 2'b11) ex_bht_new = ex_bht_old + 2'd1;
        end else begin
            if (ex_bht_old != 2'b00) ex_bht_new = ex_bht_old - 2'd1;
        end
    end

    always_comb begin
        prediction_status = 2'd2;
        if (ex_branch) begin
            case ({EX_branch_prediction[1], EX_taken})
                2'b00:   prediction_status = 2'd2;
                2'b01:   prediction_status = 2'd0;
                2'b10:   prediction_status = 2'd1;
                default: prediction_status = 2'd3;
            endcase
        end
    end

    assign mispredict = ex_branch & ~prediction_status[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
        end else if (ex_branch) begin
            bht[ex_bht_idx] <= ex_bht_new;
            if (EX_taken) begin
                btb_valid[ex_btb_idx]     <= 1'b1;
                btb_tag[ex_btb_idx]       <= ex_tag;
                btb_target[ex_btb_idx]    <= EX_pc_imm;
                btb_is_branch[ex_btb_idx] <= 1'b1;
                btb_is_jump[ex_btb_idx]   <= 1'b0;
            end
        end else if (ex_jal) begin
            btb_valid[ex_btb_idx]     <= 1'b1;
            btb_tag[ex_btb_idx]       <= ex_tag;
            btb_target[ex_btb_idx]    <= EX_pc_imm;
            btb_is_branch[ex_btb_idx] <= 1'b0;
            btb_is_jump[ex_btb_idx]   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_count     <= 32'd0;
            mispredict_count <= 32'd0;
        end else begin
            if (ex_branch && branch_count != 32'hFFFF_FFFF)
                branch_count <= branch_count + 32'd1;
            if (mispredict && mispredict_count != 32'hFFFF_FFFF)
                mispredict_count <= mispredict_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed test-plan scenarios followed by
// randomized traffic, all compared against a table-level reference model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] IF1_pc;
    logic        IF1_BTBhit, IF1_Branch, IF1_Jump;
    logic [1:0]  IF1_branch_prediction;
    logic [31:0] IF1_pc_imm;
    logic        EX_valid, EX_Branch, EX_Jump, EX_ALUSrc, EX_taken;
    logic [31:0] EX_pc, EX_pc_imm;
    logic [1:0]  EX_branch_prediction;
    logic [1:0]  prediction_status;
    logic [31:0] branch_count, mispredict_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: BTB as plain arrays indexed by (pc/4) mod 64, tag = pc/256
    bit          m_valid  [64];
    logic [31:0] m_tag    [64];
    logic [31:0] m_target [64];
    bit          m_isbr   [64];
    bit          m_isj    [64];
    int          m_bht    [256];
    longint      m_bc, m_mc;

    branch_predictor dut (
        .clk(clk), .rst_n(rst_n), .IF1_pc(IF1_pc),
        .IF1_BTBhit(IF1_BTBhit), .IF1_Branch(IF1_Branch), .IF1_Jump(IF1_Jump),
        .IF1_branch_prediction(IF1_branch_prediction), .IF1_pc_imm(IF1_pc_imm),
        .EX_valid(EX_valid), .EX_Branch(EX_Branch), .EX_Jump(EX_Jump), .EX_ALUSrc(EX_ALUSrc),
        .EX_pc(EX_pc), .EX_pc_imm(EX_pc_imm), .EX_taken(EX_taken),
        .EX_branch_prediction(EX_branch_prediction), .prediction_status(prediction_status),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    function automatic int btb_idx(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic int bht_idx(input logic [31:0] pc);
        return int'((pc / 4) % 256);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 0;
        for (int i = 0; i < 256; i++) m_bht[i] = 1;
        m_bc = 0;
        m_mc = 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of stimulus, check outputs before the edge, then advance the model.
    task automatic applyStimulus(input logic rst, input logic [31:0] lpc,
                                 input logic v, input logic br, input logic jmp, input logic alu,
                                 input logic [31:0] epc, input logic [31:0] eimm,
                                 input logic tk, input logic [1:0] pred);
        int  bi, hi, e_status;
        bit  hit, pred_tk;
        @(negedge clk);
        rst_n = rst; IF1_pc = lpc;
        EX_valid = v; EX_Branch = br; EX_Jump = jmp; EX_ALUSrc = alu;
        EX_pc = epc; EX_pc_imm = eimm; EX_taken = tk; EX_branch_prediction = pred;
        #2;
        bi  = btb_idx(lpc);
        hit = m_valid[bi] && (m_tag[bi] == lpc / 256);
        checkOutput("hit",    {31'd0, IF1_BTBhit}, {31'd0, hit});
        checkOutput("branch", {31'd0, IF1_Branch}, {31'd0, hit && m_isbr[bi]});
        checkOutput("jump",   {31'd0, IF1_Jump},   {31'd0, hit && m_isj[bi]});
        checkOutput("imm",    IF1_pc_imm, hit ? m_target[bi] : 32'd0);
        checkOutput("pred",   {30'd0, IF1_branch_prediction}, 32'(m_bht[bht_idx(lpc)]));
        pred_tk = pred >= 2;
        if (!(v && br))          e_status = 2;
        else if (pred_tk == tk)  e_status = tk ? 3 : 2;
        else                     e_status = tk ? 0 : 1;
        checkOutput("status", {30'd0, prediction_status}, 32'(e_status));
        checkOutput("bcount", branch_count, 32'(m_bc));
        checkOutput("mcount", mispredict_count, 32'(m_mc));
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (v && br) begin
            hi = bht_idx(epc);
            m_bht[hi] = tk ? ((m_bht[hi] < 3) ? m_bht[hi] + 1 : 3)
                           : ((m_bht[hi] > 0) ? m_bht[hi] - 1 : 0);
            if (tk) begin
                bi = btb_idx(epc);
                m_valid[bi] = 1; m_tag[bi] = epc / 256; m_target[bi] = eimm;
                m_isbr[bi] = 1; m_isj[bi] = 0;
            end
            if (m_bc < 64'hFFFF_FFFF) m_bc++;
            if (e_status < 2 && m_mc < 64'hFFFF_FFFF) m_mc++;
        end else if (v && jmp && !alu) begin
            bi = btb_idx(epc);
            m_valid[bi] = 1; m_tag[bi] = epc / 256; m_target[bi] = eimm;
            m_isbr[bi] = 0; m_isj[bi] = 1;
        end
        #1;
        rst_n = 1'b1; EX_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_pc();
        return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    initial begin
        logic [31:0] lpc, epc;
        logic [1:0]  pred;
        int          kind;
        bit          v, br, jmp, alu;

        rst_n = 1'b0; IF1_pc = 32'h100;
        EX_valid = 0; EX_Branch = 0; EX_Jump = 0; EX_ALUSrc = 0;
        EX_pc = 0; EX_pc_imm = 0; EX_taken = 0; EX_branch_prediction = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Post-reset lookup
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 2'b00);

        // Train a taken branch at 0x100 -> 0x80
        applyStimulus(1, 32'h100, 1, 1, 0, 0, 32'h100, 32'h80, 1, 2'b01);
        #3;
        checkOutput("t2_hit",  {31'd0, IF1_BTBhit}, 32'd1);
        checkOutput("t2_imm",  IF1_pc_imm, 32'h80);
        checkOutput("t2_pred", {30'd0, IF1_branch_prediction}, 32'd2);
        applyStimulus(1, 32'h100, 1, 1, 0, 0, 32'h100, 32'h80, 1, 2'b10);
        applyStimulus(1, 32'h100, 1, 1, 0, 0, 32'h100, 32'h80, 1, 2'b11);
        #3;
        checkOutput("t2_sat",  {30'd0, IF1_branch_prediction}, 32'd3);
        checkOutput("t2_bc",   branch_count, 32'd3);
        checkOutput("t2_mc",   mispredict_count, 32'd1);

        // Not-taken from strongly taken
        applyStimulus(1, 32'h100, 1, 1, 0, 0, 32'h100, 32'h80, 0, 2'b11);
        applyStimulus(1, 32'h100, 1, 1, 0, 0, 32'h100, 32'h80, 0, 2'b10);
        #3;
        checkOutput("t3_pred", {30'd0, IF1_branch_prediction}, 32'd1);
        checkOutput("t3_hit",  {31'd0, IF1_BTBhit}, 32'd1);

        // JAL aliasing onto the same BTB set
        applyStimulus(1, 32'h200, 1, 0, 1, 0, 32'h200, 32'h400, 1, 2'b00);
        applyStimulus(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 2'b00);

        // JALR never allocates; invalid EX changes nothing
        applyStimulus(1, 32'h300, 1, 0, 1, 1, 32'h300, 32'h500, 1, 2'b00);
        applyStimulus(1, 32'h300, 0, 1, 0, 0, 32'h300, 32'h500, 1, 2'b11);
        applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 2'b00);

        // Reset wins over a same-cycle update
        applyStimulus(0, 32'h100, 1, 1, 0, 0, 32'h100, 32'h80, 1, 2'b01);
        #3;
        checkOutput("t6_hit",  {31'd0, IF1_BTBhit}, 32'd0);
        checkOutput("t6_pred", {30'd0, IF1_branch_prediction}, 32'd1);
        checkOutput("t6_bc",   branch_count, 32'd0);
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 2'b00);

        // Randomized traffic over a small PC pool so hits, aliasing and same-index access occur
        for (int n = 0; n < 600; n++) begin
            epc  = rand_pc();
            lpc  = ($urandom_range(0, 7) == 0) ? epc : rand_pc();
            v    = $urandom_range(0, 9) != 0;
            kind = $urandom_range(0, 19);
            br   = kind < 10;
            jmp  = kind >= 10 && kind < 17;
            alu  = kind >= 14 && kind < 17;
            pred = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3))
                                               : 2'(m_bht[bht_idx(epc)]);
            applyStimulus(($urandom_range(0, 49) != 0), lpc, v, br, jmp, alu, epc,
                          $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), pred);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
